cache_controller: RTL and testbench
===================================

CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 Parameter WAYS, default 8, number of cache ways; fixed at 8 for this design.
REQ-002 Parameter TIMEOUT_CYCLES, default 64, maximum cycles DramReq_H may wait for DramAck_H.
REQ-003 Port Clock, input, 1 bit, single system clock; all state changes on its rising edge.
REQ-004 Port Reset_H, input, 1 bit, synchronous active-high reset.
REQ-005 Port CpuReq_H, input, 1 bit, CPU access request; held high until CpuAck_H or BusError_H is returned.
REQ-006 Port CpuWrite_H, input, 1 bit, access direction (1 = write); valid while CpuReq_H is high.
REQ-007 Port CacheEnable_H, input, 1 bit, 0 forces a bypass (no lookup use, no allocation).
REQ-008 Port ValidHit_H, input, 8 bits, per-way tag-match-and-valid from the tag compare logic.
REQ-009 Port DramAck_H, input, 1 bit, memory completion strobe.
REQ-010 Port DramReq_H, output, 1 bit, memory access request.
REQ-011 Port DramWrite_H, output, 1 bit, memory access direction.
REQ-012 Port WayLoad_H, output, 8 bits, one-hot, one-cycle load strobe for data/tag/valid of one way.
REQ-013 Port UseCache_H, output, 1 bit, selects the cache data mux (1) or DRAM data (0) toward the CPU.
REQ-014 Port Victim_H, output, 3 bits, current replacement way index.
REQ-015 Port CpuAck_H, output, 1 bit, one-cycle access-complete pulse.
REQ-016 Port BusError_H, output, 1 bit, one-cycle timeout pulse.

Function
REQ-017 FSM states: IDLE, LOOKUP, FILL, WRITE_THRU, ACK, ERROR, RELEASE.
REQ-018 IDLE: CpuReq_H=1 moves to LOOKUP on the next edge.
REQ-019 LOOKUP, one cycle: CacheEnable_H=0 -> FILL with no allocation; write -> WRITE_THRU; read with any hit -> ACK with UseCache_H=1; read miss -> FILL.
REQ-020 Multiple hits resolve to the lowest-index way, matching the data mux priority.
REQ-021 FILL: DramReq_H=1 and DramWrite_H=0 until DramAck_H=1.
REQ-022 On DramAck_H in FILL with the cache enabled: WayLoad_H=1<<Victim_H for that cycle; Victim_H increments mod 8; next state ACK with UseCache_H=0.
REQ-023 WRITE_THRU: DramReq_H=1 and DramWrite_H=1 until DramAck_H; on a write hit, WayLoad_H strobes the lowest hit way on the ack cycle; a write miss does not allocate; next state ACK.
REQ-024 Timeout counter clears on entry to FILL or WRITE_THRU; reaching TIMEOUT_CYCLES without an ack moves to ERROR with no WayLoad_H and no Victim_H change.
REQ-025 ACK drives CpuAck_H=1 for exactly one cycle; ERROR drives BusError_H=1 for exactly one cycle; both then go to RELEASE.
REQ-026 RELEASE waits for CpuReq_H=0, then goes to IDLE; this prevents double servicing of a held request.
REQ-027 Read-hit latency: request sampled at edge N, CpuAck_H high during cycle N+2.
REQ-028 DramAck_H outside FILL or WRITE_THRU is ignored; a DramAck_H on the timeout cycle counts as success.
REQ-029 UseCache_H is 0 in every state except the ACK that follows a read hit.

Reset
REQ-030 Reset_H=1 at an edge forces IDLE, Victim_H=0, timeout counter=0, and all outputs 0 after that edge, including mid-fill.

Structure
REQ-031 The package cache_pkg holds the state enum, WAYS, the way-index width, and TIMEOUT_CYCLES.
REQ-032 The sub-module cache_victim_sel contains the 3-bit round-robin counter and the one-hot decode.

Verification
REQ-033 Read hit: ValidHit_H=8'h24 -> UseCache_H=1, CpuAck_H at N+2, no DramReq_H.
REQ-034 Eight consecutive read misses -> WayLoad_H = 01,02,04,...,80, Victim_H wraps to 0.
REQ-035 Write hit on way 5 -> DramWrite_H=1, WayLoad_H=8'h20 on the ack cycle, Victim_H unchanged.
REQ-036 No DramAck_H for 64 cycles -> BusError_H pulse, WayLoad_H never asserted, return to IDLE after CpuReq_H drops.
REQ-037 Reset_H during FILL -> DramReq_H=0 and state IDLE after that edge; a late DramAck_H is ignored.
REQ-038 CacheEnable_H=0 on a read that hits -> DRAM read, UseCache_H=0, no WayLoad_H.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and sizing for the cache access controller.
package cache_pkg;
  localparam int WAYS           = 8;
  localparam int WAY_W          = $clog2(WAYS);
  localparam int TIMEOUT_CYCLES = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_FILL,
    ST_WRITE_THRU,
    ST_ACK,
    ST_ERROR,
    ST_RELEASE
  } state_t;

  // Lowest set index wins, matching the priority of the cache data mux.
  function automatic logic [WAY_W-1:0] lowest_way(input logic [WAYS-1:0] hits);
    lowest_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (hits[i]) lowest_way = WAY_W'(i);
    end
  endfunction
endpackage

// File: rtl/cache_if.sv
// CPU, tag-compare and DRAM handshake bundle seen by the cache controller.
interface cache_if;
  import cache_pkg::*;

  logic             CpuReq_H;
  logic             CpuWrite_H;
  logic             CacheEnable_H;
  logic [WAYS-1:0]  ValidHit_H;
  logic             DramAck_H;
  logic             DramReq_H;
  logic             DramWrite_H;
  logic [WAYS-1:0]  WayLoad_H;
  logic             UseCache_H;
  logic [WAY_W-1:0] Victim_H;
  logic             CpuAck_H;
  logic             BusError_H;

  modport master (
    output CpuReq_H, CpuWrite_H, CacheEnable_H, ValidHit_H, DramAck_H,
    input  DramReq_H, DramWrite_H, WayLoad_H, UseCache_H, Victim_H, CpuAck_H, BusError_H
  );

  modport slave (
    input  CpuReq_H, CpuWrite_H, CacheEnable_H, ValidHit_H, DramAck_H,
    output DramReq_H, DramWrite_H, WayLoad_H, UseCache_H, Victim_H, CpuAck_H, BusError_H
  );
endinterface

// File: rtl/cache_victim_sel.sv
// Round-robin replacement pointer; wraps naturally at the way count.
module cache_victim_sel
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  output logic [WAY_W-1:0] victim,
  output logic [WAYS-1:0]  victim_onehot
);

  always_ff @(posedge clk) begin
    if (rst) begin
      victim <= '0;
    end else if (advance) begin
      victim <= victim + 1'b1;
    end
  end

  always_comb begin
    victim_onehot         = '0;
    victim_onehot[victim] = 1'b1;
  end

endmodule

// File: rtl/cache_controller.sv
// Cache access sequencer: tag lookup, read-allocate fill, write-through,
// DRAM timeout and request release handshake.
//
// state       | meaning
// ------------+------------------------------------------------------
// IDLE        | waiting for a CPU request
// LOOKUP      | one cycle: classify hit/miss, write, or bypass
// FILL        | DRAM read; allocates the victim way on ack if enabled
// WRITE_THRU  | DRAM write; refreshes the hit way on ack
// ACK         | one-cycle CpuAck_H
// ERROR       | one-cycle BusError_H after a DRAM timeout
// RELEASE     | wait for the CPU to drop its request
module cache_controller
  import cache_pkg::*;
#(
  parameter int WAYS           = cache_pkg::WAYS,
  parameter int TIMEOUT_CYCLES = cache_pkg::TIMEOUT_CYCLES
) (
  input  logic  Clock,
  input  logic  Reset_H,
  cache_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [WAYS-1:0]    hit_vec;
  logic               any_hit;
  logic               rd_hit_q;
  logic               wr_hit_q;
  logic               alloc_q;
  logic [WAY_W-1:0]   hit_way_q;

  logic               advance;
  logic [WAY_W-1:0]   victim;
  logic [WAYS-1:0]    victim_onehot;

  logic               dram_req;
  logic               dram_write;
  logic [WAYS-1:0]    way_load;
  logic               use_cache;
  logic               cpu_ack;
  logic               bus_error;

  assign hit_vec = bus.ValidHit_H;
  assign any_hit = |hit_vec;

  cache_victim_sel u_victim (
    .clk           (Clock),
    .rst           (Reset_H),
    .advance       (advance),
    .victim        (victim),
    .victim_onehot (victim_onehot)
  );

  always_ff @(posedge Clock) begin
    if (Reset_H) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      rd_hit_q  <= 1'b0;
      wr_hit_q  <= 1'b0;
      alloc_q   <= 1'b0;
      hit_way_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      // Lookup outcome is frozen so later tag changes cannot redirect the access.
      if (state == ST_LOOKUP) begin
        alloc_q   <= bus.CacheEnable_H;
        rd_hit_q  <= bus.CacheEnable_H && !bus.CpuWrite_H && any_hit;
        wr_hit_q  <= bus.CacheEnable_H && bus.CpuWrite_H && any_hit;
        hit_way_q <= lowest_way(hit_vec);
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = '0;
    dram_req   = 1'b0;
    dram_write = 1'b0;
    way_load   = '0;
    use_cache  = 1'b0;
    cpu_ack    = 1'b0;
    bus_error  = 1'b0;
    advance    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (bus.CpuReq_H) state_nxt = ST_LOOKUP;
      end

      ST_LOOKUP: begin
        if (!bus.CacheEnable_H)   state_nxt = ST_FILL;
        else if (bus.CpuWrite_H)  state_nxt = ST_WRITE_THRU;
        else if (any_hit)         state_nxt = ST_ACK;
        else                      state_nxt = ST_FILL;
      end

      ST_FILL: begin
        dram_req = 1'b1;
        if (bus.DramAck_H) begin
          if (alloc_q) begin
            way_load = victim_onehot;
            advance  = 1'b1;
          end
          state_nxt = ST_ACK;
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_nxt = ST_ERROR;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      ST_WRITE_THRU: begin
        dram_req   = 1'b1;
        dram_write = 1'b1;
        if (bus.DramAck_H) begin
          if (wr_hit_q) way_load = {{(WAYS-1){1'b0}}, 1'b1} << hit_way_q;
          state_nxt = ST_ACK;
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_nxt = ST_ERROR;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      ST_ACK: begin
        cpu_ack   = 1'b1;
        use_cache = rd_hit_q;
        state_nxt = ST_RELEASE;
      end

      ST_ERROR: begin
        bus_error = 1'b1;
        state_nxt = ST_RELEASE;
      end

      ST_RELEASE: begin
        if (!bus.CpuReq_H) state_nxt = ST_IDLE;
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.DramReq_H   = dram_req;
  assign bus.DramWrite_H = dram_write;
  assign bus.WayLoad_H   = way_load;
  assign bus.UseCache_H  = use_cache;
  assign bus.Victim_H    = victim;
  assign bus.CpuAck_H    = cpu_ack;
  assign bus.BusError_H  = bus_error;

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench: a transaction-level timeline model predicts every cycle's
// outputs; literal checks pin the key latencies and strobe patterns.
module tb_cache_controller;

  localparam int TO = 64;

  logic clk;
  logic rst;

  cache_if bus();

  cache_controller #(.WAYS(8), .TIMEOUT_CYCLES(TO)) dut (
    .Clock   (clk),
    .Reset_H (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] v;
    int          idx;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] wl_log[$];
  int         checks   = 0;
  int         failures = 0;
  int         drv_idx  = 0;
  int         ack_idx  = -1;
  int         err_cnt  = 0;
  int         dreq_cnt = 0;
  int         last_vic = 0;
  int         m_vic    = 0;

  // {DramReq, DramWrite, WayLoad[7:0], UseCache, Victim[2:0], CpuAck, BusError}
  function automatic logic [15:0] ev(bit dreq, bit dwr, logic [7:0] wl, bit uc,
                                     int vic, bit ack, bit err);
    logic [2:0] v;
    v = 3'(vic);
    return {dreq, dwr, wl, uc, v, ack, err};
  endfunction

  function automatic logic [7:0] low_bit(logic [7:0] h);
    for (int i = 0; i < 8; i++) if (h[i]) return 8'(1 << i);
    return 8'h00;
  endfunction

  // Compare process: one check per driven cycle.
  logic [15:0] act;
  exp_t        cur;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      act = {bus.DramReq_H, bus.DramWrite_H, bus.WayLoad_H, bus.UseCache_H,
             bus.Victim_H, bus.CpuAck_H, bus.BusError_H};
      checks++;
      if (act !== cur.v) begin
        failures++;
        $display("FAIL outputs{dreq,dwr,wl,uc,vic,ack,err} cycle %0d: actual %h required %h",
                 cur.idx, act, cur.v);
      end
      if (bus.WayLoad_H != 8'h00) wl_log.push_back(bus.WayLoad_H);
      if (bus.CpuAck_H)   ack_idx = cur.idx;
      if (bus.BusError_H) err_cnt++;
      if (bus.DramReq_H)  dreq_cnt++;
      last_vic = int'(bus.Victim_H);
    end
  end

  task automatic lit(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: actual %0d required %0d", name, got, want);
    end
  endtask

  task automatic cyc(input bit req, input bit wr, input bit en, input logic [7:0] hit,
                     input bit dack, input bit rst_in, input logic [15:0] e);
    exp_t x;
    @(posedge clk);
    #1;
    rst               = rst_in;
    bus.CpuReq_H      = req;
    bus.CpuWrite_H    = wr;
    bus.CacheEnable_H = en;
    bus.ValidHit_H    = hit;
    bus.DramAck_H     = dack;
    drv_idx++;
    x.v   = e;
    x.idx = drv_idx;
    exp_q.push_back(x);
  endtask

  task automatic sync();
    @(negedge clk);
    #1;
  endtask

  // One complete CPU access; ack_at < 0 or >= TO means DRAM never answers.
  task automatic txn(input bit wr, input bit en, input logic [7:0] hit,
                     input int ack_at, input int hold, input bit stray);
    bit         done;
    bit         dw;
    logic [7:0] wl;
    logic [15:0] z;
    z = ev(0, 0, 8'h00, 0, m_vic, 0, 0);
    cyc(1, wr, en, hit, stray, 0, z);
    cyc(1, wr, en, hit, stray, 0, z);
    if (!wr && en && hit != 8'h00) begin
      cyc(1, wr, en, hit, stray, 0, ev(0, 0, 8'h00, 1, m_vic, 1, 0));
    end else begin
      done = 0;
      dw   = wr && en;
      for (int d = 0; d < TO; d++) begin
        if (d == ack_at) begin
          if (wr) wl = en ? low_bit(hit) : 8'h00;
          else    wl = en ? 8'(1 << m_vic) : 8'h00;
          cyc(1, wr, en, hit, 1, 0, ev(1, dw, wl, 0, m_vic, 0, 0));
          if (!wr && en) m_vic = (m_vic + 1) % 8;
          done = 1;
          break;
        end
        cyc(1, wr, en, hit, 0, 0, ev(1, dw, 8'h00, 0, m_vic, 0, 0));
      end
      cyc(1, wr, en, hit, stray, 0, ev(0, 0, 8'h00, 0, m_vic, done, !done));
    end
    z = ev(0, 0, 8'h00, 0, m_vic, 0, 0);
    repeat (hold) cyc(1, wr, en, hit, stray, 0, z);
    cyc(0, wr, en, hit, stray, 0, z);
    cyc(0, 0, 1, 8'h00, 0, 0, z);
  endtask

  logic [7:0] tbl[8];
  int t0, d0, w0, e0;

  initial begin
    rst               = 1'b1;
    bus.CpuReq_H      = 1'b0;
    bus.CpuWrite_H    = 1'b0;
    bus.CacheEnable_H = 1'b1;
    bus.ValidHit_H    = 8'h00;
    bus.DramAck_H     = 1'b0;
    tbl = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    repeat (3) cyc(0, 0, 1, 8'h00, 0, 1, ev(0, 0, 8'h00, 0, 0, 0, 0));
    cyc(0, 0, 1, 8'h00, 0, 0, ev(0, 0, 8'h00, 0, 0, 0, 0));

    // Read hit on ways 2 and 5, stray DRAM acks outside the DRAM phase.
    t0 = drv_idx + 1;
    d0 = dreq_cnt;
    txn(0, 1, 8'h24, 0, 2, 1);
    sync();
    lit("rd_hit_ack_latency", ack_idx - t0, 2);
    lit("rd_hit_no_dram", dreq_cnt - d0, 0);

    // Eight read misses fill ways 0..7 in order.
    w0 = wl_log.size();
    for (int i = 0; i < 8; i++) txn(0, 1, 8'h00, i, i % 3, 0);
    sync();
    for (int i = 0; i < 8; i++) lit("miss_wayload", int'(wl_log[w0 + i]), int'(tbl[i]));
    lit("miss_victim_wrap", last_vic, 0);

    // Write hit on way 5, then a multi-hit write resolving to way 3.
    txn(1, 1, 8'h20, 2, 0, 0);
    sync();
    lit("wr_hit_wayload", int'(wl_log[wl_log.size() - 1]), 32);
    lit("wr_hit_victim", last_vic, 0);
    txn(1, 1, 8'h28, 0, 1, 0);
    sync();
    lit("wr_multi_wayload", int'(wl_log[wl_log.size() - 1]), 8);

    // Write miss and disabled read hit: no allocation.
    w0 = wl_log.size();
    txn(1, 1, 8'h00, 1, 0, 0);
    txn(0, 0, 8'h24, 3, 1, 0);
    sync();
    lit("no_alloc_wayload", wl_log.size() - w0, 0);

    // Ack on the last allowed cycle succeeds.
    txn(0, 1, 8'h00, TO - 1, 0, 0);
    sync();
    lit("late_ack_victim", last_vic, 1);

    // Read and write timeouts.
    w0 = wl_log.size();
    e0 = err_cnt;
    txn(0, 1, 8'h00, -1, 3, 0);
    txn(1, 1, 8'h04, -1, 0, 0);
    sync();
    lit("timeout_errors", err_cnt - e0, 2);
    lit("timeout_no_wayload", wl_log.size() - w0, 0);
    lit("timeout_victim", last_vic, 1);

    txn(0, 1, 8'h00, 0, 0, 0);

    // Reset in the middle of a fill, then a late ack.
    cyc(1, 0, 1, 8'h00, 0, 0, ev(0, 0, 8'h00, 0, m_vic, 0, 0));
    cyc(1, 0, 1, 8'h00, 0, 0, ev(0, 0, 8'h00, 0, m_vic, 0, 0));
    repeat (3) cyc(1, 0, 1, 8'h00, 0, 0, ev(1, 0, 8'h00, 0, m_vic, 0, 0));
    cyc(1, 0, 1, 8'h00, 0, 1, ev(1, 0, 8'h00, 0, m_vic, 0, 0));
    m_vic = 0;
    cyc(0, 0, 1, 8'h00, 1, 0, ev(0, 0, 8'h00, 0, 0, 0, 0));
    cyc(0, 0, 1, 8'h00, 0, 0, ev(0, 0, 8'h00, 0, 0, 0, 0));
    sync();
    lit("reset_victim", last_vic, 0);
    txn(0, 1, 8'h00, 1, 0, 0);
    sync();
    lit("post_reset_wayload", int'(wl_log[wl_log.size() - 1]), 1);

    // Every way hitting still serves from cache.
    txn(0, 1, 8'hFF, 0, 0, 0);
    sync();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
